bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
Four-master bus arbiter that sits directly upstream of the bus master multiplexer. It generates the mX_grnt signals that select which master's address, control and write data drive the shared slave side. Arbitration is round-robin with ownership held while the master keeps requesting. A hold-time limit forces handover when other masters are waiting.

Parameters:
HOLD_MAX, 256, maximum consecutive grant cycles for one owner while another master requests; 0 disables the limit
CNT_WIDTH, 9, hold-counter width; must satisfy 2**CNT_WIDTH > HOLD_MAX

Ports:
clk_i  input  1  bus clock; single clock domain
rst_n_i  input  1  asynchronous active-low reset
m0_req_i  input  1  master 0 bus request
m1_req_i  input  1  master 1 bus request
m2_req_i  input  1  master 2 bus request
m3_req_i  input  1  master 3 bus request
m0_grnt_o  output  1  master 0 granted (registered)
m1_grnt_o  output  1  master 1 granted (registered)
m2_grnt_o  output  1  master 2 granted (registered)
m3_grnt_o  output  1  master 3 granted (registered)
owner_o  output  2  index of current or last owner (registered)
busy_o  output  1  1 while any grant is asserted
timeout_o  output  1  one-cycle pulse when a grant is revoked by HOLD_MAX

Behaviour:
- Reset (async assert, sync release): all grants 0, busy_o 0, timeout_o 0, owner_o 2'd3, hold counter 0, state ARB_IDLE. Because owner_o resets to 3, the first pick starts at master 0.
- Reset mid-transfer drops all grants immediately. No request state is retained.
- Grant vector is one-hot or all-zero in every cycle; never more than one grant.
- Round-robin pick: scan masters owner_o+1, +2, +3, +4 (mod 4) and take the first with req=1.
- State ARB_IDLE:
  - any req=1 at a clock edge -> grant the picked master at that edge (1-cycle latency req->grnt), owner_o=pick, counter=0, go ARB_OWN.
- State ARB_OWN, evaluated each edge:
  - Owner req=1 and no forced handover: keep the grant. Counter increments, saturating at 2**CNT_WIDTH-1.
  - Owner req=0 and another req=1: grant the next pick at that same edge. Zero-bubble handover; counter=0.
  - Owner req=0 and no req: all grants 0, go ARB_IDLE. owner_o keeps the last owner.
  - Forced handover: HOLD_MAX!=0, counter==HOLD_MAX-1, owner req=1 and at least one other req=1. Grant the next pick excluding the owner, counter=0, timeout_o=1 for exactly that cycle.
  - Owner at limit with no other requester: keeps the grant, no timeout pulse. Handover occurs at the first edge where another request is seen.
- A revoked master must drop req or re-request. Its new request enters normal round-robin with lowest priority.
- Simultaneous requests at reset release: m0 wins, then m1, m2, m3 in rotation.
- Requests are sampled only at clock edges. A req pulse shorter than a cycle between edges is ignored.
- busy_o = OR of grants (registered alongside them). timeout_o is 0 whenever not forced.

Decomposition:
- Shared package bus_pkg:
  - typedef logic [1:0] bus_mst_idx_t
  - enum arb_state_e {ARB_IDLE, ARB_OWN}
  - localparam BUS_MST_NUM = 4
- Sub-module bus_rr_pick: purely combinational round-robin picker.
  - Inputs: 4-bit request vector, last-owner index, exclude-mask.
  - Outputs: valid and index.
- The FSM, hold counter and registered outputs stay in bus_arbiter.

Test Plan:
1. Reset, then m2_req_i=1 at cycle 5 -> m2_grnt_o=1 at edge 6, owner_o=2, busy_o=1; other grants 0 throughout.
2. All four reqs held high from reset release, each owner drops req after 3 granted cycles -> grant order m0, m1, m2, m3, m0, with no idle cycle between owners.
3. m1 owns; m1_req drops at the same edge m3_req rises -> m3_grnt_o=1 at that edge, m1_grnt_o=0, counter restarts at 0.
4. HOLD_MAX=8: m0 holds req, m2 requests at granted cycle 2 -> m0_grnt drops and m2_grnt rises after 8 granted cycles of m0, timeout_o=1 for one cycle.
5. HOLD_MAX=8: m0 holds for 20 cycles alone -> grant kept, timeout_o stays 0; m1 requests at cycle 20 -> handover at the next edge with timeout_o pulse.
6. rst_n_i driven low mid-grant between clock edges -> all grants, busy_o and timeout_o 0 immediately, owner_o=3. After release, priority restarts at m0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the four-master bus arbiter.
package bus_pkg;

  localparam int BUS_MST_NUM = 4;

  typedef logic [1:0] bus_mst_idx_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_OWN
  } arb_state_e;

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational round-robin picker: scans last+1 .. last+4 (mod 4) and
// returns the first eligible requester.
module bus_rr_pick
  import bus_pkg::*;
(
  input  logic [BUS_MST_NUM-1:0] req,
  input  bus_mst_idx_t           last,
  input  logic [BUS_MST_NUM-1:0] excl,
  output logic                   valid,
  output bus_mst_idx_t           idx
);

  logic [BUS_MST_NUM-1:0] elig;
  bus_mst_idx_t           cand;

  always_comb begin
    elig  = req & ~excl;
    valid = 1'b0;
    idx   = last;
    cand  = last;
    // The final step wraps back to 'last' itself, giving it lowest priority.
    for (int i = 1; i <= BUS_MST_NUM; i++) begin
      cand = last + bus_mst_idx_t'(i);
      if (!valid && elig[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with ownership hold and a hold-time
// limit that forces handover when other masters are waiting.
//
// state    | meaning
// ARB_IDLE | no grant asserted; owner_o holds the last owner
// ARB_OWN  | exactly one grant asserted; hold counter running
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int HOLD_MAX  = 256,
  parameter int CNT_WIDTH = 9
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         m0_req_i,
  input  logic         m1_req_i,
  input  logic         m2_req_i,
  input  logic         m3_req_i,
  output logic         m0_grnt_o,
  output logic         m1_grnt_o,
  output logic         m2_grnt_o,
  output logic         m3_grnt_o,
  output bus_mst_idx_t owner_o,
  output logic         busy_o,
  output logic         timeout_o
);

  localparam logic [CNT_WIDTH-1:0] HOLD_LAST =
    (HOLD_MAX == 0) ? '0 : CNT_WIDTH'(HOLD_MAX - 1);
  localparam logic HOLD_EN = (HOLD_MAX != 0);

  arb_state_e             state_q, state_d;
  logic [BUS_MST_NUM-1:0] grnt_q, grnt_d;
  bus_mst_idx_t           owner_q, owner_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   timeout_q, timeout_d;
  logic                   busy_q;

  logic [BUS_MST_NUM-1:0] req;
  logic [BUS_MST_NUM-1:0] owner_mask;
  logic [BUS_MST_NUM-1:0] excl;
  logic                   owner_req;
  logic                   force_ho;
  logic                   pick_vld;
  bus_mst_idx_t           pick_idx;

  assign req        = {m3_req_i, m2_req_i, m1_req_i, m0_req_i};
  assign owner_mask = BUS_MST_NUM'(1) << owner_q;
  assign owner_req  = req[owner_q];
  // '>=' keeps the limit armed once an unchallenged owner has run past it.
  assign force_ho   = HOLD_EN && (cnt_q >= HOLD_LAST) && owner_req
                      && (|(req & ~owner_mask));
  assign excl       = (state_q == ARB_OWN) ? owner_mask : '0;

  bus_rr_pick u_pick (
    .req   (req),
    .last  (owner_q),
    .excl  (excl),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    grnt_d    = grnt_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          grnt_d  = BUS_MST_NUM'(1) << pick_idx;
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = ARB_OWN;
        end
      end
      ARB_OWN: begin
        if (owner_req && !force_ho) begin
          if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
        end else if (pick_vld) begin
          grnt_d    = BUS_MST_NUM'(1) << pick_idx;
          owner_d   = pick_idx;
          cnt_d     = '0;
          timeout_d = force_ho;
        end else begin
          grnt_d  = '0;
          cnt_d   = '0;
          state_d = ARB_IDLE;
        end
      end
      default: begin
        grnt_d  = '0;
        cnt_d   = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ARB_IDLE;
      grnt_q    <= '0;
      owner_q   <= bus_mst_idx_t'(3);
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grnt_q    <= grnt_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      busy_q    <= |grnt_d;
    end
  end

  assign m0_grnt_o = grnt_q[0];
  assign m1_grnt_o = grnt_q[1];
  assign m2_grnt_o = grnt_q[2];
  assign m3_grnt_o = grnt_q[3];
  assign owner_o   = owner_q;
  assign busy_o    = busy_q;
  assign timeout_o = timeout_q;

endmodule
